// File: rtl/spu_issue_scoreboard.sv
// spu_issue_scoreboard: N-way in-order issue stage with a per-register latency scoreboard.
// Issue is in order. A lane is accepted only when lane 0 up to and including that lane is
// free of RAW/WAW hazards. Accepted lanes are captured into the fetch-stage output
// register. Each destination then arms a countdown that blocks readers until its result
// can be forwarded.
// Optional build macro SPU_SB_STATS_EN adds two outputs, stall_cycles and issued_count.
module spu_issue_scoreboard #(
    parameter int ISSUE_WIDTH    = 2,
    parameter int NUM_REGS       = 128,
    parameter int REG_ADDR_WIDTH = 7,
    parameter int LAT_WIDTH      = 3,
    parameter int PAYLOAD_WIDTH  = 64
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    flush,
    input  logic [ISSUE_WIDTH-1:0]                  in_valid,
    input  logic [ISSUE_WIDTH*3*REG_ADDR_WIDTH-1:0] in_src_addr,
    input  logic [ISSUE_WIDTH*3-1:0]                in_src_use,
    input  logic [ISSUE_WIDTH*REG_ADDR_WIDTH-1:0]   in_rt_addr,
    input  logic [ISSUE_WIDTH-1:0]                  in_wr_en,
    input  logic [ISSUE_WIDTH*LAT_WIDTH-1:0]        in_lat,
    input  logic [ISSUE_WIDTH*PAYLOAD_WIDTH-1:0]    in_payload,
    output logic [ISSUE_WIDTH-1:0]                  in_issued,
    output logic [ISSUE_WIDTH-1:0]                  out_valid,
    output logic [ISSUE_WIDTH*3*REG_ADDR_WIDTH-1:0] out_src_addr,
    output logic [ISSUE_WIDTH*REG_ADDR_WIDTH-1:0]   out_rt_addr,
    output logic [ISSUE_WIDTH-1:0]                  out_wr_en,
    output logic [ISSUE_WIDTH*LAT_WIDTH-1:0]        out_lat,
    output logic [ISSUE_WIDTH*PAYLOAD_WIDTH-1:0]    out_payload
`ifdef SPU_SB_STATS_EN
    ,
    output logic [31:0]                             stall_cycles,
    output logic [31:0]                             issued_count
`endif
);

    localparam int SRC_W = 3 * REG_ADDR_WIDTH;

    // A latency of 0 behaves exactly like a latency of 1.
    function automatic logic [LAT_WIDTH-1:0] eff_lat(input logic [LAT_WIDTH-1:0] l);
        return (l == '0) ? LAT_WIDTH'(1) : l;
    endfunction

    logic [REG_ADDR_WIDTH-1:0] lane_src [ISSUE_WIDTH][3];
    logic [REG_ADDR_WIDTH-1:0] lane_rt  [ISSUE_WIDTH];
    logic [LAT_WIDTH-1:0]      lane_lat [ISSUE_WIDTH];
    logic [REG_ADDR_WIDTH-1:0] held_rt  [ISSUE_WIDTH];
    logic [LAT_WIDTH-1:0]      held_lat [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0]    held_wr;
    logic [ISSUE_WIDTH-1:0]    lane_elig;
    logic                      prefix_ok;

    logic [LAT_WIDTH-1:0] sb_reg  [NUM_REGS];
    logic [LAT_WIDTH-1:0] sb_next [NUM_REGS];

    // Per-lane unpacking and hazard evaluation
    generate
        for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_lane
            logic elig;

            for (genvar si = 0; si < 3; si++) begin : g_src
                assign lane_src[gi][si] = in_src_addr[(gi*3+si)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            end
            assign lane_rt[gi]  = in_rt_addr[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            assign lane_lat[gi] = eff_lat(in_lat[gi*LAT_WIDTH +: LAT_WIDTH]);
            assign held_rt[gi]  = out_rt_addr[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            assign held_lat[gi] = eff_lat(out_lat[gi*LAT_WIDTH +: LAT_WIDTH]);
            assign held_wr[gi]  = out_valid[gi] & out_wr_en[gi];
            assign lane_elig[gi] = elig;

            // Lane is eligible when its sources are ready and its destination write cannot overtake an older one
            always_comb begin
                elig = in_valid[gi];
                for (int s = 0; s < 3; s++) begin
                    if (in_src_use[gi*3+s]) begin
                        if (sb_reg[lane_src[gi][s]] != '0) begin
                            elig = 1'b0;
                        end
                        for (int o = 0; o < ISSUE_WIDTH; o++) begin
                            if (held_wr[o] && held_rt[o] == lane_src[gi][s]) begin
                                elig = 1'b0;
                            end
                        end
                        for (int j = 0; j < gi; j++) begin
                            if (in_valid[j] && in_wr_en[j] && lane_rt[j] == lane_src[gi][s]) begin
                                elig = 1'b0;
                            end
                        end
                    end
                end
                if (in_wr_en[gi]) begin
                    if (sb_reg[lane_rt[gi]] > lane_lat[gi]) begin
                        elig = 1'b0;
                    end
                    for (int o = 0; o < ISSUE_WIDTH; o++) begin
                        if (held_wr[o] && held_rt[o] == lane_rt[gi] && held_lat[o] > lane_lat[gi]) begin
                            elig = 1'b0;
                        end
                    end
                    for (int j = 0; j < gi; j++) begin
                        if (in_valid[j] && in_wr_en[j] && lane_rt[j] == lane_rt[gi] &&
                            lane_lat[j] > lane_lat[gi]) begin
                            elig = 1'b0;
                        end
                    end
                end
            end
        end
    endgenerate

    // Only the longest eligible prefix issues; reset and flush block all issue
    always_comb begin
        in_issued = '0;
        prefix_ok = ~reset & ~flush;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            prefix_ok    = prefix_ok & lane_elig[k];
            in_issued[k] = prefix_ok;
        end
    end

    // Next counter value: age by one, then take the larger of that and any arming write
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            logic [LAT_WIDTH-1:0] nxt;

            assign sb_next[gi] = nxt;

            always_comb begin
                nxt = (sb_reg[gi] != '0) ? sb_reg[gi] - LAT_WIDTH'(1) : '0;
                for (int o = 0; o < ISSUE_WIDTH; o++) begin
                    if (held_wr[o] && !flush && held_rt[o] == REG_ADDR_WIDTH'(gi) &&
                        (held_lat[o] - LAT_WIDTH'(1)) > nxt) begin
                        nxt = held_lat[o] - LAT_WIDTH'(1);
                    end
                end
            end
        end
    endgenerate

    // Scoreboard counter state
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reset) begin
                sb_reg[r] <= '0;
            end else begin
                sb_reg[r] <= sb_next[r];
            end
        end
    end

    // Fetch-stage output register: valid follows issue, fields hold when the lane is not reloaded
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= '0;
            out_src_addr <= '0;
            out_rt_addr  <= '0;
            out_wr_en    <= '0;
            out_lat      <= '0;
            out_payload  <= '0;
        end else begin
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                out_valid[k] <= in_issued[k] & ~flush;
                if (in_issued[k]) begin
                    out_src_addr[k*SRC_W +: SRC_W]                   <= in_src_addr[k*SRC_W +: SRC_W];
                    out_rt_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]  <= in_rt_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                    out_wr_en[k]                                     <= in_wr_en[k];
                    out_lat[k*LAT_WIDTH +: LAT_WIDTH]                <= in_lat[k*LAT_WIDTH +: LAT_WIDTH];
                    out_payload[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]    <= in_payload[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
                end
            end
        end
    end

`ifdef SPU_SB_STATS_EN
    // Stall and throughput counters; both wrap silently
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            issued_count <= '0;
        end else begin
            if (in_valid[0] && !in_issued[0] && !flush) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            issued_count <= issued_count + 32'($countones(in_issued));
        end
    end
`endif

endmodule

// File: doc/spu_issue_scoreboard.md
Name: spu_issue_scoreboard

Overview:
- Parametrised N-way in-order issue stage with per-register latency scoreboard. Generalises the dual-issue register fetch stage.
- Sits between decode and the register file / forwarding network. It latches up to ISSUE_WIDTH lanes into the fetch-stage register only when their source operands are available.
- Holds back RAW/WAW-hazarded lanes and younger lanes. Supports branch flush and per-lane unit latency.

Parameters:
- ISSUE_WIDTH, 2, number of issue lanes; lane 0 is oldest.
- NUM_REGS, 128, architectural register count.
- REG_ADDR_WIDTH, 7, register address width, ≥ clog2(NUM_REGS).
- LAT_WIDTH, 3, width of the latency field and of the scoreboard counters.
- PAYLOAD_WIDTH, 64, opaque per-lane payload (unit id, opcode, immediates), passed through unchanged.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- flush  in  1  branch flush; kills the fetch-stage register and blocks issue.
- in_valid  in  ISSUE_WIDTH  per-lane instruction valid.
- in_src_addr  in  ISSUE_WIDTH*3*REG_ADDR_WIDTH  ra/rb/rc addresses per lane.
- in_src_use  in  ISSUE_WIDTH*3  per-source "operand used" flag.
- in_rt_addr  in  ISSUE_WIDTH*REG_ADDR_WIDTH  destination address.
- in_wr_en  in  ISSUE_WIDTH  lane writes rt.
- in_lat  in  ISSUE_WIDTH*LAT_WIDTH  cycles until the result is forwardable; 0 is treated as 1.
- in_payload  in  ISSUE_WIDTH*PAYLOAD_WIDTH  passthrough.
- in_issued  out  ISSUE_WIDTH  combinational; lane accepted this cycle.
- out_valid  out  ISSUE_WIDTH  registered.
- out_src_addr, out_rt_addr, out_wr_en, out_lat, out_payload  out  same widths as inputs  registered copies.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - all scoreboard counters sb[r] = 0.
  - out_valid = 0.
  - all other out_* = 0.
  - reset overrides flush and issue.
  - in_issued is combinationally 0 while reset is high.
- Scoreboard aging: each cycle, every nonzero sb[r] decrements by 1, saturating at 0. Aging continues during flush.
- Lane k is eligible only if all of the following hold:
  - in_valid[k]=1.
  - For every used source s: sb[s]==0.
  - For every used source s: s ≠ out_rt_addr of any out lane with out_valid & out_wr_en.
  - For every used source s: s ≠ in_rt_addr of any lane j<k with in_valid & in_wr_en.
  - WAW check, if in_wr_en[k]: sb[rt] ≤ effective lat, and rt not equal to any older same-bundle or out-register destination with a larger lat.
- Issue rule:
  - in_issued = longest eligible prefix starting at lane 0; lane k issues only if lanes 0..k-1 also issue.
  - Lanes after the first non-eligible lane are held.
  - Upstream re-presents held lanes next cycle, shifted to lane 0.
  - flush=1 forces in_issued=0.
- Fetch register update, each edge:
  - out_valid[k] <= in_issued[k] & ~flush.
  - Other out_* fields load from the matching lane when in_issued[k]=1, otherwise hold.
  - Latency from input to output register is 1 cycle.
- Scoreboard set: at each edge where out_valid[k] & out_wr_en[k] & ~flush, sb[out_rt_addr[k]] <= max(eff_lat-1, aged value).
- Simultaneous set and decrement: set wins.
- Same-register set from two out lanes: the larger value wins.
- Flush:
  - Current out lanes are discarded and do not set the scoreboard.
  - Counters for older in-flight instructions are not cleared.
- Back-to-back dependency: a consumer of a lat=1 producer issues exactly 1 cycle after the producer leaves the output register. In general, the consumer issues eff_lat cycles after the producer is in out.

Optional Feature:
- Macro: SPU_SB_STATS_EN.
- Defined: adds outputs stall_cycles [32] and issued_count [32]. Both reset to 0 and wrap on overflow.
  - stall_cycles increments when in_valid[0]=1 & in_issued[0]=0 & ~flush.
  - issued_count adds popcount(in_issued) each cycle.
- Undefined: neither port nor counter exists. Issue behaviour is identical in both builds.

Test Plan:
- Reset, then lane0 add r3←r1,r2 lat=2, lane1 or r5←r4 → both in_issued=11; out_valid=11 next cycle; sb[3]=1 the cycle after.
- Lane1 sources r3, which lane0 writes in the same bundle → in_issued=01. Re-presented lane issues exactly 2 cycles after producer capture (lat=2).
- Producer r10 lat=7 in out; consumer of r10 presented continuously → in_issued=0 for 7 cycles, then 1. stall_cycles=7 with SPU_SB_STATS_EN.
- WAW: r8 lat=6 pending, new write r8 lat=2 → held until sb[8]≤2, then issues.
- flush with out_valid=11 writing r20/r21 → out_valid=00 next edge, sb[20]=sb[21]=0. A consumer of r20 issues immediately after flush drops.
- reset asserted while sb[9]=5 and out_valid=10 → next cycle all sb=0, out_valid=0, in_issued=0 during reset.
